// File: rtl/div_unit.sv
// Iterative restoring divider for div/divu/rem/remu, producing one quotient bit per cycle.
// The optional macro DIV_FAST_SPECIAL_EN lets divide-by-zero and signed overflow skip the iteration.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int CW = $clog2(XLEN + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q, result_q, special_val_q;
  logic            is_rem_q, neg_q_q, neg_r_q, special_q;

  // Request decode: op[0] selects unsigned, op[1] selects remainder.
  logic            accept, is_signed, a_neg, b_neg, div_zero, overflow, special;
  logic [XLEN-1:0] a_mag, b_mag, special_val;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign accept    = in_valid && in_ready;

  assign is_signed   = ~op[0];
  assign a_neg       = is_signed & srcA[XLEN-1];
  assign b_neg       = is_signed & srcB[XLEN-1];
  assign a_mag       = a_neg ? -srcA : srcA;
  assign b_mag       = b_neg ? -srcB : srcB;
  assign div_zero    = (srcB == '0);
  assign overflow    = is_signed && (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1);
  assign special     = div_zero | overflow;
  assign special_val = div_zero ? (op[1] ? srcA : '1) : (op[1] ? '0 : srcA);

  // One restoring step: dividend bits leave quo_q at the top while quotient bits enter at the bottom.
  logic [XLEN:0]   trial;
  logic            take;
  logic [XLEN-1:0] rem_step, quo_step, q_fix, r_fix, final_val;

  assign trial     = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
  assign take      = ~trial[XLEN];
  assign rem_step  = take ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
  assign quo_step  = {quo_q[XLEN-2:0], take};
  assign q_fix     = neg_q_q ? -quo_step : quo_step;
  assign r_fix     = neg_r_q ? -rem_step : rem_step;
  assign final_val = special_q ? special_val_q : (is_rem_q ? r_fix : q_fix);

  // NOTE: state_d gets a default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef DIV_FAST_SPECIAL_EN
          state_d = special ? DONE : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC:    if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      result_q      <= '0;
      quo_q         <= '0;
      rem_q         <= '0;
      dvs_q         <= '0;
      special_val_q <= '0;
      is_rem_q      <= 1'b0;
      neg_q_q       <= 1'b0;
      neg_r_q       <= 1'b0;
      special_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        quo_q         <= a_mag;
        rem_q         <= '0;
        dvs_q         <= b_mag;
        is_rem_q      <= op[1];
        neg_q_q       <= a_neg ^ b_neg;
        neg_r_q       <= a_neg;
        special_q     <= special;
        special_val_q <= special_val;
        cnt_q         <= CW'(XLEN);
`ifdef DIV_FAST_SPECIAL_EN
        if (special) begin
          result_q <= special_val;
          cnt_q    <= '0;
        end
`endif
      end else if (state_q == CALC) begin
        quo_q <= quo_step;
        rem_q <= rem_step;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) result_q <= final_val;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operations against an arithmetic model.
// Define DIV_FAST_SPECIAL_EN for both bench and RTL to exercise the fast special-case build.
module tb_div_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] srcA, srcB, result;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .srcA(srcA), .srcB(srcB),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Reference: plain SV arithmetic (truncating division, remainder takes the dividend's sign).
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq;
    sa = a;
    sb = b;
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
    case (o)
      2'b00:   sq = sa / sb;
      2'b10:   sq = sa % sb;
      2'b01:   sq = a / b;
      default: sq = a % b;
    endcase
    return sq;
  endfunction

  function automatic int exp_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_SPECIAL_EN
    return is_special(o, a, b) ? 1 : XLEN + 1;
`else
    return XLEN + 1;
`endif
  endfunction

  // Called just after a falling edge; returns just after a falling edge with the unit idle again.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int stall);
    logic [31:0] exp_res, held;
    int lat;
    exp_res = model(o, a, b);
    check({tag, " in_ready before"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = o; srcA = a; srcB = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_latency(o, a, b)));
    check({tag, " result"}, 64'(result), 64'(exp_res));
    held = result;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, " stall hold"}, {31'd0, out_valid, in_ready, result}, {31'd0, 1'b1, 1'b0, held});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " after handshake"}, {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
  endtask

  // Aborts a request 10 cycles into CALC, either by flush or by reset.
  task automatic abort_op(input string tag, input logic use_rst);
    int seen;
    in_valid = 1'b1; op = 2'b01; srcA = 32'd1000; srcB = 32'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    check({tag, " idle next cycle"}, {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check({tag, " no out_valid"}, 64'(seen), 64'd0);
    run_op({tag, " then divu 9/3"}, 2'b01, 32'd9, 32'd3, 0);
  endtask

  initial begin
    int seen;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; srcA = '0; srcB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset state", {31'd0, in_ready, out_valid, result}, {31'd0, 1'b1, 1'b0, 32'd0});

    run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 0);
    run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 0);
    run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("div 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 0);
    run_op("divu x/0", 2'b01, 32'h1234, 32'd0, 0);
    run_op("remu x/0", 2'b11, 32'h1234, 32'd0, 0);
    run_op("div -5/0", 2'b00, 32'hFFFF_FFFB, 32'd0, 0);
    run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu max", 2'b01, 32'hFFFF_FFFF, 32'd1, 0);

    // Output back-pressure, then a request in the very cycle in_ready returns.
    run_op("stall div", 2'b00, 32'hFFFF_FF00, 32'd17, 5);
    run_op("back-to-back remu", 2'b11, 32'd12345, 32'd100, 0);

    abort_op("flush", 1'b0);
    abort_op("rst", 1'b1);

    // A request accepted in the same cycle as flush is dropped.
    in_valid = 1'b1; flush = 1'b1; op = 2'b01; srcA = 32'd50; srcB = 32'd5;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen++;
    end
    check("flush on accept dropped", 64'(seen), 64'd0);

    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      case ($urandom_range(0, 9))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 15));
        2:       r_b = 32'hFFFF_FFFF;
        3: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        4:       r_b = $urandom >> $urandom_range(0, 31);
        default: r_b = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  synchronous abort of any operation in progress.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port op  input  2  operation select: 00 div, 01 divu, 10 rem, 11 remu.
REQ-008 SHALL have port srcA  input  XLEN  dividend.
REQ-009 SHALL have port srcB  input  XLEN  divisor.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  XLEN  quotient or remainder per op.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 SHALL accept a request on a rising edge with in_valid && in_ready, latching op, operand magnitudes and result signs.
REQ-015 SHALL transition IDLE->CALC on accept, with iteration counter loaded to XLEN.
REQ-016 SHALL produce one quotient bit per CALC cycle (restoring shift-subtract on magnitudes); transition CALC->DONE after exactly XLEN iterations.
REQ-017 SHALL assert out_valid XLEN+1 cycles after the accept edge for normal operands (33 for XLEN=32).
REQ-018 SHALL, for div/rem, treat operands as two's complement: quotient negative iff operand signs differ; remainder sign equals dividend sign; magnitude |A| = |B|*|Q| + |R|, |R| < |B|.
REQ-019 SHALL, for divu/remu, treat operands as unsigned.
REQ-020 SHALL, on divisor zero, return all-ones for div/divu and srcA for rem/remu.
REQ-021 SHALL, on signed overflow (srcA = most negative value, srcB = all ones, op div/rem), return srcA for div and 0 for rem.
REQ-022 SHALL hold result stable and out_valid high in DONE until out_valid && out_ready, then transition DONE->IDLE on that edge.
REQ-023 SHALL not accept a new request while in CALC or DONE (in_ready low); in_ready SHALL rise the cycle after the output handshake.
REQ-024 SHALL treat flush as highest priority after rst: next state IDLE, out_valid low, any request accepted in the same cycle discarded.
REQ-025 SHALL leave result a don't-care when out_valid is low.

Reset
REQ-026 SHALL, on rst high at a rising edge, enter IDLE regardless of state, including mid-CALC or DONE with result not yet taken.
REQ-027 SHALL drive after reset: in_ready=1, out_valid=0, result=0, counter=0.
REQ-028 SHALL give rst priority over flush, in_valid and out_ready.

Configuration
REQ-029 SHALL support macro DIV_FAST_SPECIAL_EN: when defined, divisor-zero and signed-overflow requests go IDLE->DONE directly, out_valid asserted 1 cycle after accept.
REQ-030 SHALL, without DIV_FAST_SPECIAL_EN, process special cases through CALC with the normal XLEN+1 latency; result values per REQ-020/021 are identical in both builds.

Verification
REQ-031 SHALL cover: divu 100/7 -> result 14, out_valid 33 cycles after accept; remu 100/7 -> 2.
REQ-032 SHALL cover: div 0xFFFFFFF9/2 (-7/2) -> 0xFFFFFFFD (-3); rem -> 0xFFFFFFFF (-1); div 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-033 SHALL cover: divu 0x1234/0 -> 0xFFFFFFFF, remu -> 0x1234; latency 1 with DIV_FAST_SPECIAL_EN, 33 without.
REQ-034 SHALL cover: div 0x80000000/0xFFFFFFFF -> 0x80000000; rem -> 0x00000000.
REQ-035 SHALL cover: out_ready low 5 cycles in DONE -> result and out_valid stable, in_ready 0; handshake -> in_ready 1 next cycle, back-to-back request accepted.
REQ-036 SHALL cover: flush (and separately rst) at CALC cycle 10 -> next cycle IDLE, out_valid never asserts for that request, following divu 9/3 returns 3.
